spi_mem_loader: RTL and testbench

SPI_MEM_LOADER -- requirements
Module: spi_mem_loader

---
 rtl/spi_mem_loader.sv | 260 ++++++++++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_loader
// Purpose  : Serial loader that writes or reads one of N_TGT memories. Each
//            frame carries a W/R bit, an address and a data word, MSB first,
//            with one bit transferred per clk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int N_TGT  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_TGT-1:0]        cs_n_i,
  input  logic                    mosi_i,
  input  logic                    lock_i,
  input  logic                    err_clr_i,
  input  logic [N_TGT*DATA_W-1:0] rd_data_i,
  output logic [N_TGT-1:0]        wr_en_o,
  output logic [N_TGT-1:0]        rd_en_o,
  output logic [ADDR_W-1:0]       addr_o,
  output logic [DATA_W-1:0]       wr_data_o,
  output logic                    miso_o,
  output logic                    miso_oe_o,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [7:0]              frame_cnt_o
);

  localparam int c_max_w = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int c_cnt_w = $clog2(c_max_w) + 1;
  localparam int c_tgt_w = (N_TGT > 1) ? $clog2(N_TGT) : 1;

  localparam logic [c_cnt_w-1:0] c_addr_last = c_cnt_w'(ADDR_W - 1);
  localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    TURN  = 3'd3,
    WDATA = 3'd4,
    RDATA = 3'd5,
    HOLD  = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [c_tgt_w-1:0]   tgt_q, tgt_d;
  logic                 is_wr_q, is_wr_d;
  logic                 armed_q, armed_d;
  logic [ADDR_W-1:0]    addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0]    sh_q, sh_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [N_TGT-1:0]     wr_en_q, wr_en_d;
  logic                 err_q, err_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;

  logic [N_TGT-1:0]     cs_low;
  logic                 cs_any;
  logic                 cs_one;
  logic [c_tgt_w-1:0]   cs_idx;
  logic [N_TGT-1:0]     tgt_oh;
  logic                 cs_ok;
  logic [ADDR_W-1:0]    addr_shift_in;
  logic [DATA_W-1:0]    data_shift_in;
  logic [DATA_W-1:0]    data_shift_out;
  logic [DATA_W-1:0]    rd_sel;
  logic                 err_set;
  logic                 done;

  // Chip-select decode: which target is low, and whether the frame's target is still the only one low
  always_comb begin
    cs_low = ~cs_n_i;
    cs_any = (cs_low != '0);
    cs_one = cs_any && ((cs_low & (cs_low - N_TGT'(1))) == '0);
    cs_idx = '0;
    for (int t = 0; t < N_TGT; t++) begin
      if (cs_low[t]) cs_idx = c_tgt_w'(t);
    end
    tgt_oh = N_TGT'(1) << tgt_q;
    cs_ok  = (cs_low == tgt_oh);
    // Width casts keep the shifts valid for one-bit addresses
    addr_shift_in  = ADDR_W'({addr_sh_q, mosi_i});
    data_shift_in  = DATA_W'({sh_q, mosi_i});
    data_shift_out = DATA_W'({sh_q, 1'b0});
  end

  // Read-data mux for the latched target
  always_comb begin
    rd_sel = '0;
    for (int t = 0; t < N_TGT; t++) begin
      if (tgt_q == c_tgt_w'(t)) rd_sel = rd_data_i[t*DATA_W +: DATA_W];
    end
  end

  // Frame FSM: next state, shift registers and completion strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    is_wr_d   = is_wr_q;
    addr_sh_d = addr_sh_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = '0;
    err_set   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        // A fresh assertion is required; the sampled bit is the W/R flag
        if (armed_q && cs_any) begin
          if (!cs_one || lock_i) begin
            err_set = 1'b1;
          end else begin
            state_d = CMD;
            tgt_d   = cs_idx;
            is_wr_d = mosi_i;
            cnt_d   = '0;
          end
        end
      end
      CMD, ADDR: begin
        if (!cs_ok) begin
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          addr_sh_d = addr_shift_in;
          if (cnt_q == c_addr_last) begin
            cnt_d = '0;
            if (is_wr_q) begin
              state_d = WDATA;
            end else begin
              // Address must be valid during the turnaround cycle
              state_d = TURN;
              addr_d  = addr_shift_in;
            end
          end else begin
            cnt_d   = cnt_q + c_cnt_one;
            state_d = ADDR;
          end
        end
      end
      TURN: begin
        if (!cs_ok) begin
          err_set = 1'b1;
          state_d = HOLD;
        end else begin
          sh_d    = rd_sel;
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
      WDATA: begin
        if (!cs_ok) begin
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          sh_d = data_shift_in;
          if (cnt_q == c_data_last) begin
            wr_en_d   = tgt_oh;
            addr_d    = addr_sh_q;
            wr_data_d = data_shift_in;
            done      = 1'b1;
            cnt_d     = '0;
            state_d   = HOLD;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
      end
      RDATA: begin
        if (!cs_ok) begin
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          sh_d = data_shift_out;
          if (cnt_q == c_data_last) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
      end
      HOLD: begin
        if (!cs_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Error flag, good-frame counter and re-arm tracking
  always_comb begin
    if (err_set)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;

    frame_cnt_d = frame_cnt_q;
    if (done && (frame_cnt_q != 8'hFF)) frame_cnt_d = frame_cnt_q + 8'd1;

    // Seeing all selects high re-arms frame start; an IDLE error disarms it
    if (!cs_any)                            armed_d = 1'b1;
    else if ((state_q == IDLE) && err_set)  armed_d = 1'b0;
    else                                    armed_d = armed_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      is_wr_q     <= 1'b0;
      armed_q     <= 1'b0;
      addr_sh_q   <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      is_wr_q     <= is_wr_d;
      armed_q     <= armed_d;
      addr_sh_q   <= addr_sh_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Read strobe is suppressed if the select is lost during turnaround
  assign rd_en_o     = ((state_q == TURN) && cs_ok) ? tgt_oh : '0;
  assign wr_en_o     = wr_en_q;
  assign addr_o      = addr_q;
  assign wr_data_o   = wr_data_q;
  assign miso_oe_o   = (state_q == RDATA);
  assign miso_o      = (state_q == RDATA) && sh_q[DATA_W-1];
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_loader
// Purpose  : Self-checking bench for spi_mem_loader. Frames are described at
//            the transaction level and expected outputs per cycle follow from
//            the frame position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mem_loader;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NT = 2;
  localparam int RW = NT * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NT-1:0] cs_n;
  logic          mosi, lock, clr;
  logic [RW-1:0] rdd;
  logic [NT-1:0] wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          miso, miso_oe, busy, err;
  logic [7:0]    fcnt;

  // expected per-cycle outputs and model state
  logic [NT-1:0] e_wr, e_rd;
  logic          e_miso, e_oe, e_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic          m_err;
  logic [7:0]    m_cnt;
  bit            chk_en, rnd_clr;
  int            n_cmp, n_bad;

  // observation snapshots owned by the compare process
  logic [NT-1:0] obs_wr, obs_rd;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wd, obs_miso;
  int            obs_nbits;
  logic [7:0]    obs_cnt;
  logic          obs_err, obs_busy_any;
  int            clear_gen, seen_gen;

  spi_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .N_TGT(NT)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n_i(cs_n), .mosi_i(mosi), .lock_i(lock),
    .err_clr_i(clr), .rd_data_i(rdd), .wr_en_o(wr_en), .rd_en_o(rd_en),
    .addr_o(addr), .wr_data_o(wr_data), .miso_o(miso), .miso_oe_o(miso_oe),
    .busy_o(busy), .err_o(err), .frame_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // single compare process: every cycle against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_en_o",     32'(wr_en),   32'(e_wr));
      chk("rd_en_o",     32'(rd_en),   32'(e_rd));
      chk("miso_o",      32'(miso),    32'(e_miso));
      chk("miso_oe_o",   32'(miso_oe), 32'(e_oe));
      chk("busy_o",      32'(busy),    32'(e_busy));
      chk("err_o",       32'(err),     32'(m_err));
      chk("frame_cnt_o", 32'(fcnt),    32'(m_cnt));
      chk("addr_o",      32'(addr),    32'(m_addr));
      chk("wr_data_o",   32'(wr_data), 32'(m_wd));
    end
    if (seen_gen != clear_gen) begin
      seen_gen     = clear_gen;
      obs_wr       = '0;
      obs_rd       = '0;
      obs_addr     = '0;
      obs_wd       = '0;
      obs_miso     = '0;
      obs_nbits    = 0;
      obs_busy_any = 1'b0;
    end
    if (wr_en != '0) begin obs_wr = wr_en; obs_addr = addr; obs_wd = wr_data; end
    if (rd_en != '0) obs_rd = rd_en;
    if (miso_oe) begin obs_miso = {obs_miso[DW-2:0], miso}; obs_nbits++; end
    obs_cnt      = fcnt;
    obs_err      = err;
    obs_busy_any = obs_busy_any | busy;
  end

  // advance one cycle; a clear pulse from the previous cycle takes effect now
  task automatic nxt();
    @(posedge clk);
    #1;
    if (clr) m_err = 1'b0;
    clr = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    clear_gen++;
  endtask

  task automatic zero_exp();
    e_wr = '0; e_rd = '0; e_miso = 1'b0; e_oe = 1'b0; e_busy = 1'b0;
  endtask

  // one cycle with every select high; assumes the DUT is (or returns) to idle
  task automatic idle_cyc();
    cs_n = '1;
    mosi = 1'($urandom);
    lock = 1'($urandom);
    rdd  = RW'($urandom);
    clr  = rnd_clr && ($urandom_range(7, 0) == 0);
    zero_exp();
  endtask

  task automatic reset_pulse();
    nxt();
    rst_n = 1'b0; cs_n = '1; clr = 1'b0;
    zero_exp();
    m_addr = '0; m_wd = '0; m_err = 1'b0; m_cnt = '0;
    nxt(); rst_n = 1'b1; idle_cyc();
    nxt(); idle_cyc();
  endtask

  // kind: 0 release all, 1 all low, 2 other target, 3 reset pulse
  task automatic frame(input bit rw, input int tgt, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int abort_at, input int kind,
                       input int gap);
    int            len;
    logic          seq[$];
    logic [NT-1:0] oh;
    bit            aborted;
    oh  = NT'(1) << tgt;
    len = rw ? 1 + AW + DW : 2 + AW + DW;
    seq.push_back(rw);
    for (int i = AW - 1; i >= 0; i--) seq.push_back(a[i]);
    if (!rw) seq.push_back(1'($urandom));
    for (int i = DW - 1; i >= 0; i--) seq.push_back(d[i]);
    aborted = 1'b0;
    for (int k = 0; k < len; k++) begin
      nxt();
      mosi = seq[k];
      lock = (k == 0) ? 1'b0 : 1'($urandom);
      clr  = rnd_clr && ($urandom_range(7, 0) == 0);
      rdd  = RW'($urandom);
      if (!rw && k == AW + 1) rdd[tgt*DW +: DW] = d;
      cs_n = ~oh;
      if (k == abort_at) begin
        case (kind)
          0:       cs_n = '1;
          1:       cs_n = '0;
          2:       cs_n = ~(NT'(1) << ((tgt + 1) % NT));
          default: rst_n = 1'b0;
        endcase
      end
      e_wr   = '0;
      e_busy = (k != 0);
      e_rd   = (!rw && k == AW + 1 && k != abort_at) ? oh : '0;
      if (!rw && k == AW + 1) m_addr = a;
      e_oe   = (!rw && k >= AW + 2);
      e_miso = e_oe ? d[DW - 1 - (k - AW - 2)] : 1'b0;
      if (k == abort_at) begin
        aborted = 1'b1;
        if (kind == 3) begin
          zero_exp();
          m_addr = '0; m_wd = '0; m_err = 1'b0; m_cnt = '0;
        end
        break;
      end
    end
    if (aborted && kind == 3) begin
      // select still low after release: no frame may start
      for (int i = 0; i < 2; i++) begin
        nxt();
        if (i == 0) rst_n = 1'b1;
        cs_n = ~oh; mosi = 1'($urandom); lock = 1'b0;
        zero_exp();
      end
      nxt(); idle_cyc();
    end else begin
      nxt();
      idle_cyc();
      e_busy = 1'b1;
      if (aborted) begin
        m_err = 1'b1;
      end else begin
        if (rw) begin e_wr = oh; m_addr = a; m_wd = d; end
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
    for (int g = 0; g < gap; g++) begin
      nxt(); idle_cyc();
    end
    settle();
  endtask

  // kind 0: more than one select low; kind 1: select low while locked
  task automatic idle_err(input int kind);
    logic [NT-1:0] oh;
    oh = NT'(1) << $urandom_range(NT - 1, 0);
    nxt();
    clr = 1'b0; mosi = 1'($urandom);
    cs_n = (kind == 0) ? '0 : ~oh;
    lock = (kind == 1);
    zero_exp();
    nxt(); m_err = 1'b1;
    nxt(); cs_n = '1; lock = 1'b0;
    nxt(); idle_cyc();
    settle();
  endtask

  task automatic rand_frame(input bit allow_abort);
    bit rw;
    int len, at;
    rw  = 1'($urandom);
    len = rw ? 1 + AW + DW : 2 + AW + DW;
    at  = (allow_abort && $urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 1)) : -1;
    frame(rw, $urandom_range(NT - 1, 0), AW'($urandom), DW'($urandom), at,
          $urandom_range(2, 0), $urandom_range(2, 0));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; clear_gen = 1; seen_gen = 0;
    rst_n = 1'b0; cs_n = '1; mosi = 1'b0; lock = 1'b0; clr = 1'b0; rdd = '0;
    rnd_clr = 1'b0;
    zero_exp();
    m_addr = '0; m_wd = '0; m_err = 1'b0; m_cnt = '0;
    chk_en = 1'b1;
    nxt(); nxt();
    rst_n = 1'b1;
    nxt(); idle_cyc();

    // write: cs 2'b10, W=1, addr 0101, data 10100011
    clear_obs();
    frame(1'b1, 0, 4'b0101, 8'b10100011, -1, 0, 1);
    chk("lit_wr_en",   32'(obs_wr),   32'h1);
    chk("lit_wr_addr", 32'(obs_addr), 32'h5);
    chk("lit_wr_data", 32'(obs_wd),   32'hA3);
    chk("lit_wr_cnt",  32'(obs_cnt),  32'd1);

    // read: cs 2'b01, addr 1111, target 1 returns 8'h5C
    reset_pulse();
    clear_obs();
    frame(1'b0, 1, 4'b1111, 8'h5C, -1, 0, 1);
    chk("lit_rd_en",   32'(obs_rd),    32'h2);
    chk("lit_rd_miso", 32'(obs_miso),  32'b01011100);
    chk("lit_rd_bits", 32'(obs_nbits), 32'd8);
    chk("lit_rd_cnt",  32'(obs_cnt),   32'd1);

    // select released after 7 write bits, then a clear pulse
    clear_obs();
    frame(1'b1, 0, 4'h3, 8'h77, 7, 0, 1);
    chk("lit_abort_wr",  32'(obs_wr),  32'h0);
    chk("lit_abort_err", 32'(obs_err), 32'h1);
    nxt(); idle_cyc(); clr = 1'b1;
    nxt(); idle_cyc();
    settle();
    chk("lit_clr_err", 32'(obs_err), 32'h0);

    // conflict, then lock at frame start
    clear_obs();
    idle_err(0);
    chk("lit_multi_err", 32'(obs_err), 32'h1);
    chk("lit_multi_wr",  32'(obs_wr),  32'h0);
    chk("lit_multi_rd",  32'(obs_rd),  32'h0);
    nxt(); idle_cyc(); clr = 1'b1;
    nxt(); idle_cyc();
    clear_obs();
    idle_err(1);
    chk("lit_lock_err",  32'(obs_err),      32'h1);
    chk("lit_lock_busy", 32'(obs_busy_any), 32'h0);

    // reset during the data phase, then a normal frame
    clear_obs();
    frame(1'b1, 1, 4'h9, 8'h3C, AW + 3, 3, 0);
    chk("lit_rst_wr",  32'(obs_wr),  32'h0);
    chk("lit_rst_cnt", 32'(obs_cnt), 32'h0);
    frame(1'b1, 0, 4'hC, 8'h5A, -1, 0, 1);
    chk("lit_post_rst_cnt", 32'(obs_cnt), 32'd1);
    chk("lit_post_rst_wr",  32'(obs_wr),  32'h1);

    // randomized traffic with aborts, clears and idle errors
    rnd_clr = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(9, 0) == 0) idle_err($urandom_range(1, 0));
      else rand_frame(1'b1);
    end
    rnd_clr = 1'b0;

    // saturation from a clean count
    reset_pulse();
    for (int i = 0; i < 256; i++) begin
      frame(1'b1, $urandom_range(NT - 1, 0), AW'($urandom), DW'($urandom), -1, 0, 0);
    end
    chk("lit_sat_256", 32'(obs_cnt), 32'd255);
    frame(1'b1, 1, 4'h1, 8'h01, -1, 0, 1);
    chk("lit_sat_257", 32'(obs_cnt), 32'd255);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
